// File: rtl/countdown_seconds.sv
// countdown_seconds: counts a game round down in whole seconds with binary and BCD readout.
// Define COUNTDOWN_WARN_EN to build the low-time warn output; otherwise warn is tied low.
module countdown_seconds #(
  parameter int SEC_WIDTH    = 7,
  parameter int MAX_SECONDS  = 99,
  parameter int WARN_SECONDS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 pause,
  input  logic [SEC_WIDTH-1:0] load_value,
  output logic                 timer_en,
  output logic [SEC_WIDTH-1:0] remaining,
  output logic [3:0]           bcd_tens,
  output logic [3:0]           bcd_ones,
  output logic                 running,
  output logic                 done,
  output logic                 expired,
  output logic                 warn
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE} state_t;

  localparam logic [SEC_WIDTH-1:0] MAX_S = SEC_WIDTH'(MAX_SECONDS);
  localparam logic [SEC_WIDTH-1:0] ONE   = SEC_WIDTH'(1);
  localparam logic [SEC_WIDTH-1:0] TEN   = SEC_WIDTH'(10);

  // Two BCD digits must cover every loadable value.
  if (MAX_SECONDS > 99 || WARN_SECONDS > MAX_SECONDS) begin : g_bad_params
    $error("countdown_seconds: MAX_SECONDS must be <= 99 and WARN_SECONDS <= MAX_SECONDS");
  end

  state_t               state_q, state_d;
  logic [SEC_WIDTH-1:0] remaining_q, remaining_d;
  logic [SEC_WIDTH-1:0] load_clamped;
  logic [3:0]           tens_q, tens_d, ones_q, ones_d;
  logic                 run_q, done_q;
  logic                 expired_q, expired_d;

  assign load_clamped = (load_value > MAX_S) ? MAX_S : load_value;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    if (start) begin
      // A fresh load wins over any tick or pause arriving in the same cycle.
      remaining_d = load_clamped;
      if (load_clamped == '0) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick && remaining_q > ONE) begin
            remaining_d = remaining_q - ONE;
          end else if (tick && remaining_q == ONE) begin
            remaining_d = '0;
            state_d     = ST_DONE;
            expired_d   = 1'b1;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!pause) state_d = ST_RUN;
        end
        ST_DONE: remaining_d = '0;
        default: state_d = state_q;
      endcase
    end
  end

  // Digits are derived from the next value so they change together with remaining.
  always_comb begin
    tens_d = 4'(remaining_d / TEN);
    ones_d = 4'(remaining_d % TEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      run_q       <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
      expired_q   <= expired_d;
    end
  end

  assign timer_en  = run_q;
  assign running   = run_q;
  assign done      = done_q;
  assign expired   = expired_q;
  assign remaining = remaining_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;

`ifdef COUNTDOWN_WARN_EN
  logic warn_q, warn_d;

  always_comb begin
    warn_d = ((state_d == ST_RUN) || (state_d == ST_PAUSED)) &&
             (remaining_d != '0) && (remaining_d <= SEC_WIDTH'(WARN_SECONDS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) warn_q <= 1'b0;
    else        warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule
